systolic_result_drain: RTL

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain_if.sv | 31 +++
 rtl/systolic_result_drain.sv | 116 +++++++++++
 2 files changed

// File: rtl/systolic_result_drain_if.sv
// Stream bundle between the systolic array, the result drain and its consumer.
// The drain owns the master side; the consumer/array side uses the slave modport.
interface systolic_result_drain_if #(
    parameter int N    = 16,
    parameter int AROW = 4,
    parameter int BCOL = 4
);
    localparam int RW = (AROW > 1) ? $clog2(AROW) : 1;
    localparam int CW = (BCOL > 1) ? $clog2(BCOL) : 1;

    logic                                    start;
    logic [AROW-1:0][BCOL-1:0][2*N-1:0]      sys_array;
    logic [N-1:0]                            out_data;
    logic [RW-1:0]                           out_row;
    logic [CW-1:0]                           out_col;
    logic                                    out_valid;
    logic                                    out_ready;
    logic                                    out_last;
    logic                                    busy;
    logic                                    sat;

    modport master (
        input  start, sys_array, out_ready,
        output out_data, out_row, out_col, out_valid, out_last, busy, sat
    );

    modport slave (
        output start, sys_array, out_ready,
        input  out_data, out_row, out_col, out_valid, out_last, busy, sat
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array LATENCY cycles after start, then streams requantised elements row-major.
// Optional ReLU before requantisation is enabled by defining RESULT_DRAIN_RELU_EN.
module systolic_result_drain #(
    parameter int N       = 16,
    parameter int AROW    = 4,
    parameter int BCOL    = 4,
    parameter int LATENCY = 10,
    parameter int SHIFT   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    systolic_result_drain_if.master  bus
);
    localparam int RW   = (AROW > 1) ? $clog2(AROW) : 1;
    localparam int CW   = (BCOL > 1) ? $clog2(BCOL) : 1;
    localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic signed [2*N-1:0] QMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] QMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t                              state_q, state_d;
    logic [CNTW-1:0]                     cnt_q;
    logic [AROW-1:0][BCOL-1:0][2*N-1:0]  snap_q;
    logic [RW-1:0]                       row_q;
    logic [CW-1:0]                       col_q;
    logic                                sat_q;

    logic                                lat_done;
    logic                                is_last;
    logic                                fire;
    logic signed [2*N-1:0]               elem;
    logic signed [2*N-1:0]               pre;
    logic signed [2*N-1:0]               shifted;
    logic                                clamp_hi;
    logic                                clamp_lo;
    logic [N-1:0]                        qdata;

    assign lat_done = (cnt_q == CNTW'(LATENCY - 1));
    assign is_last  = (row_q == RW'(AROW - 1)) && (col_q == CW'(BCOL - 1));
    assign fire     = (state_q == DRAIN) && bus.out_ready;

    // Requantisation works only from the snapshot, so no array input reaches an output.
    always_comb begin
        elem = snap_q[row_q][col_q];
`ifdef RESULT_DRAIN_RELU_EN
        pre = elem[2*N-1] ? '0 : elem;
`else
        pre = elem;
`endif
        shifted  = pre >>> SHIFT;
        clamp_hi = (shifted > QMAX);
        clamp_lo = (shifted < QMIN);
        if (clamp_hi)      qdata = QMAX[N-1:0];
        else if (clamp_lo) qdata = QMIN[N-1:0];
        else               qdata = shifted[N-1:0];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = WAIT;
            WAIT:    if (lat_done) state_d = DRAIN;
            DRAIN:   if (fire && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q <= '0;
                        sat_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (lat_done) snap_q <= bus.sys_array;
                    else          cnt_q  <= cnt_q + CNTW'(1);
                end
                DRAIN: begin
                    if (fire) begin
                        sat_q <= sat_q | clamp_hi | clamp_lo;
                        if (col_q == CW'(BCOL - 1)) begin
                            col_q <= '0;
                            row_q <= is_last ? '0 : row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data  = qdata;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_last  = (state_q == DRAIN) && is_last;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sat       = sat_q;
endmodule
